// File: rtl/lfsr_crypt_engine_if.sv
// Request/ack handshake plus the 1R1W data-memory port of the LFSR crypt engine.
interface lfsr_crypt_engine_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req;
   logic              ack;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // engine side
   modport master (
      input  req, rd_data,
      output ack, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   // host / memory side
   modport slave (
      output req, rd_data,
      input  ack, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-encryption engine: reads pre_length/taps/seed, pads the plaintext
// with a zero preamble, XORs each word with the LFSR sequence and writes the
// ciphertext block back to memory, one word per cycle.
module lfsr_crypt_engine #(
   parameter int LFSR_W   = 7,
   parameter int MSG_LEN  = 64,
   parameter int ADDR_W   = 8,
   parameter int SRC_BASE = 0,
   parameter int CFG_BASE = 61,
   parameter int DST_BASE = 64,
   parameter int PARITY   = 0
) (
   input  logic                clk,
   input  logic                init,
   lfsr_crypt_engine_if.master bus
);
   localparam int          KW  = $clog2(MSG_LEN + 8);
   localparam int          PW  = $clog2(MSG_LEN + 1);
   localparam logic [31:0] LEN = 32'(MSG_LEN);

   typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              req_q;
   logic [PW-1:0]     pre_q;
   logic [LFSR_W-1:0] taps_q, lfsr_q, seed_m, low;
   logic              rd_en_d, rd_src_d, rd_src_q, pad_q, msb;
   logic              wr_en_d;
   logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
   logic [31:0]       nk, src_i, src_a, pre_raw;

   // state register
   always_ff @(posedge clk) begin
      if (!init) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // k counts cycles since launch (k=1 is the first CFG cycle); every strobe for
   // cycle k+1 is derived here from k+1 so all bus outputs leave a register.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      rd_en_d   = 1'b0;
      rd_src_d  = 1'b0;
      rd_addr_d = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      nk        = 32'(k_q) + 32'd1;
      src_i     = nk - 32'd4;
      src_a     = 32'(SRC_BASE) + src_i - 32'(pre_q);
      unique case (state_q)
         IDLE: begin
            if (req_q && !bus.req) begin
               state_d   = CFG;
               k_d       = KW'(1);
               rd_en_d   = 1'b1;
               rd_addr_d = ADDR_W'(CFG_BASE);
            end
         end
         CFG, RUN: begin
            k_d = nk[KW-1:0];
            if (nk == 32'd2 || nk == 32'd3) begin
               rd_en_d   = 1'b1;
               rd_addr_d = ADDR_W'(32'(CFG_BASE) + nk - 32'd1);
            end
            if (nk >= 32'd4 && nk < LEN + 32'd4 && src_i >= 32'(pre_q)
                && src_a < 32'(CFG_BASE)) begin
               rd_en_d   = 1'b1;
               rd_src_d  = 1'b1;
               rd_addr_d = ADDR_W'(src_a);
            end
            if (nk >= 32'd5 && nk < LEN + 32'd5) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'(32'(DST_BASE) + nk - 32'd5);
            end
            if (nk >= LEN + 32'd5) state_d = DONE;
            else if (nk >= 32'd5)  state_d = RUN;
         end
         DONE: begin
            if (bus.req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // config sanitising and ciphertext word (read data arrives one cycle after rd_en)
   always_comb begin
      pre_raw = 32'(bus.rd_data);
      seed_m  = bus.rd_data[LFSR_W-1:0];
      if (seed_m == '0) seed_m = LFSR_W'(1);
      low         = (pad_q ? bus.rd_data[LFSR_W-1:0] : '0) ^ lfsr_q;
      msb         = (PARITY != 0) ? ^low : 1'b0;
      bus.wr_data = bus.wr_en ? {msb, low} : '0;
   end

   // bus strobes, config capture and LFSR stepping
   always_ff @(posedge clk) begin
      if (!init) begin
         req_q       <= 1'b0;
         k_q         <= '0;
         pre_q       <= '0;
         taps_q      <= '0;
         lfsr_q      <= '0;
         rd_src_q    <= 1'b0;
         pad_q       <= 1'b0;
         bus.ack     <= 1'b0;
         bus.rd_en   <= 1'b0;
         bus.rd_addr <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
      end else begin
         req_q       <= bus.req;
         k_q         <= k_d;
         rd_src_q    <= rd_src_d;
         pad_q       <= rd_src_q;
         bus.ack     <= (state_d == DONE);
         bus.rd_en   <= rd_en_d;
         bus.rd_addr <= rd_addr_d;
         bus.wr_en   <= wr_en_d;
         bus.wr_addr <= wr_addr_d;
         if (state_q == CFG) begin
            if (k_q == KW'(2)) pre_q  <= (pre_raw > LEN) ? PW'(MSG_LEN) : PW'(pre_raw);
            if (k_q == KW'(3)) taps_q <= bus.rd_data[LFSR_W-1:0];
            if (k_q == KW'(4)) lfsr_q <= seed_m;
         end else if (state_q == RUN) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & taps_q)};
         end
      end
   end
endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Directed bench: two engines (PARITY 0 and 1) on private memories, driven by
// the same req/init, checked against hand-computed words and a small model.
module tb_lfsr_crypt_engine;
   localparam int CFG_BASE = 61;
   localparam int DST_BASE = 64;

   logic clk  = 1'b0;
   logic init = 1'b0;
   always #5 clk = ~clk;

   lfsr_crypt_engine_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
   lfsr_crypt_engine_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

   lfsr_crypt_engine #(.LFSR_W(7), .MSG_LEN(64), .ADDR_W(8), .SRC_BASE(0),
      .CFG_BASE(61), .DST_BASE(64), .PARITY(0)) dut0 (.clk(clk), .init(init), .bus(bus0));
   lfsr_crypt_engine #(.LFSR_W(7), .MSG_LEN(64), .ADDR_W(8), .SRC_BASE(0),
      .CFG_BASE(61), .DST_BASE(64), .PARITY(1)) dut1 (.clk(clk), .init(init), .bus(bus1));

   logic [7:0] mem0  [256];
   logic [7:0] mem1  [256];
   logic [7:0] stage [256];
   logic [7:0] plain [64];
   logic [7:0] tbl   [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                              8'h41, 8'h03, 8'h06, 8'h0C, 8'h18};
   logic       do_load = 1'b0;
   logic       mon_clr = 1'b0;
   int         cyc = 0;
   int         t0, first_wr, ack_cyc, n_src;
   int         n_cmp = 0;
   int         n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous-read memories; bulk load while the engines are idle
   always @(posedge clk) begin
      if (do_load) begin
         for (int a = 0; a < 256; a++) begin
            mem0[a] = stage[a];
            mem1[a] = stage[a];
         end
      end else begin
         if (bus0.rd_en) bus0.rd_data <= mem0[bus0.rd_addr];
         if (bus1.rd_en) bus1.rd_data <= mem1[bus1.rd_addr];
         if (bus0.wr_en) mem0[bus0.wr_addr] = bus0.wr_data;
         if (bus1.wr_en) mem1[bus1.wr_addr] = bus1.wr_data;
      end
   end

   // event monitor on engine 0
   always @(negedge clk) begin
      if (mon_clr) begin
         first_wr = -1;
         ack_cyc  = -1;
         n_src    = 0;
      end else begin
         if (bus0.wr_en && first_wr < 0) first_wr = cyc;
         if (bus0.ack && ack_cyc < 0)    ack_cyc  = cyc;
         if (bus0.rd_en && bus0.rd_addr < 8'(CFG_BASE)) n_src++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model(int i, int pre, logic [7:0] taps, logic [7:0] seed, bit par);
      logic [6:0] l, t, pad, lo;
      int p;
      t = taps[6:0];
      l = seed[6:0];
      if (l == 7'd0) l = 7'd1;
      p = (pre > 64) ? 64 : pre;
      for (int n = 0; n < i; n++) l = {l[5:0], ^(l & t)};
      if (i < p || i - p >= CFG_BASE) pad = 7'd0;
      else                            pad = plain[i - p][6:0];
      lo = pad ^ l;
      return {par ? ^lo : 1'b0, lo};
   endfunction

   task automatic load(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] seed);
      for (int a = 0; a < 256; a++) stage[a] = 8'hEE;
      for (int a = 0; a < CFG_BASE; a++) stage[a] = plain[a];
      stage[CFG_BASE]     = pre;
      stage[CFG_BASE + 1] = taps;
      stage[CFG_BASE + 2] = seed;
      @(negedge clk) do_load = 1'b1;
      @(negedge clk) do_load = 1'b0;
   endtask

   task automatic launch();
      @(negedge clk);
      mon_clr = 1'b1; bus0.req = 1'b1; bus1.req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mon_clr = 1'b0; bus0.req = 1'b0; bus1.req = 1'b0;
      t0 = cyc;
   endtask

   task automatic finish_run(input string tag);
      int n;
      n = 0;
      while (n < 200 && !(bus0.ack && bus1.ack)) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".ack_seen"}, 32'(bus0.ack && bus1.ack), 32'd1);
      bus0.req = 1'b1; bus1.req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk({tag, ".ack_clear"}, 32'(bus0.ack), 32'd0);
   endtask

   task automatic check_all(input string tag, input int pre, input logic [7:0] taps, input logic [7:0] seed);
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("%s.p0[%0d]", tag, i), 32'(mem0[DST_BASE + i]), 32'(model(i, pre, taps, seed, 1'b0)));
         chk($sformatf("%s.p1[%0d]", tag, i), 32'(mem1[DST_BASE + i]), 32'(model(i, pre, taps, seed, 1'b1)));
      end
   endtask

   initial begin
      bus0.req = 1'b0; bus1.req = 1'b0;
      for (int a = 0; a < 64; a++) plain[a] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst.ack",     32'(bus0.ack),     32'd0);
      chk("rst.rd_en",   32'(bus0.rd_en),   32'd0);
      chk("rst.wr_en",   32'(bus0.wr_en),   32'd0);
      chk("rst.wr_data", 32'(bus0.wr_data), 32'd0);
      chk("rst.ack1",    32'(bus1.ack),     32'd0);
      init = 1'b1;

      // zero message, pre=10: timing, preamble words, parity variant
      load(8'd10, 8'h60, 8'h01);
      launch();
      finish_run("zero");
      chk("zero.first_wr", 32'(first_wr), 32'(t0 + 5));
      chk("zero.ack_cyc",  32'(ack_cyc),  32'(t0 + 69));
      chk("zero.n_src",    32'(n_src),    32'd54);
      for (int i = 0; i < 11; i++)
         chk($sformatf("zero.tbl[%0d]", i), 32'(mem0[DST_BASE + i]), 32'(tbl[i]));
      chk("par.dst0", 32'(mem1[DST_BASE + 0]), 32'h81);
      chk("par.dst6", 32'(mem1[DST_BASE + 6]), 32'h41);
      chk("par.dst7", 32'(mem1[DST_BASE + 7]), 32'h03);
      check_all("zero", 10, 8'h60, 8'h01);

      // one plaintext byte after the preamble
      plain[0] = 8'h2D;
      load(8'd10, 8'h60, 8'h01);
      launch();
      finish_run("msg");
      chk("msg.dst10", 32'(mem0[DST_BASE + 10]), 32'h35);
      for (int i = 0; i < 10; i++)
         chk($sformatf("msg.tbl[%0d]", i), 32'(mem0[DST_BASE + i]), 32'(tbl[i]));
      check_all("msg", 10, 8'h60, 8'h01);
      plain[0] = 8'h00;

      // zero seed behaves as seed 1
      load(8'd10, 8'h60, 8'h00);
      launch();
      finish_run("seed0");
      check_all("seed0", 10, 8'h60, 8'h01);

      // seed with out-of-range bits
      load(8'd10, 8'h60, 8'hFF);
      launch();
      finish_run("seedff");
      chk("seedff.dst0", 32'(mem0[DST_BASE + 0]), 32'h7F);
      check_all("seedff", 10, 8'h60, 8'hFF);

      // preamble longer than the block: no plaintext reads at all
      for (int a = 0; a < 64; a++) plain[a] = 8'((a * 7 + 3) & 8'h5F);
      load(8'd80, 8'h60, 8'h01);
      launch();
      finish_run("pre80");
      chk("pre80.n_src", 32'(n_src), 32'd0);
      check_all("pre80", 80, 8'h60, 8'h01);

      // no preamble: last indices fall on the config words and read as zero
      load(8'd0, 8'h60, 8'h05);
      launch();
      finish_run("pre0");
      chk("pre0.n_src", 32'(n_src), 32'd61);
      check_all("pre0", 0, 8'h60, 8'h05);

      // reset in the middle of a run, then a clean run
      load(8'd3, 8'h48, 8'h2A);
      launch();
      while (cyc < t0 + 20) @(negedge clk);
      init = 1'b0;
      @(negedge clk);
      chk("abort.ack",   32'(bus0.ack),   32'd0);
      chk("abort.wr_en", 32'(bus0.wr_en), 32'd0);
      chk("abort.rd_en", 32'(bus0.rd_en), 32'd0);
      init = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort.idle_wr", 32'(bus0.wr_en || bus0.rd_en), 32'd0);
      launch();
      finish_run("rerun");
      chk("rerun.first_wr", 32'(first_wr), 32'(t0 + 5));
      check_all("rerun", 3, 8'h48, 8'h2A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lfsr_crypt_engine.md
Name: lfsr_crypt_engine

Overview:
- Hardware LFSR stream-encryption engine for the program-1 flow: pads a message with a preamble, XORs each byte with an LFSR sequence, and writes the ciphertext block back to data memory.
- Replaces the software encryption loop and connects to a 1R1W port of the shared data memory.
- Generalised in LFSR width, block length and memory map, and adds an optional parity MSB and tap/seed sanitising.

Parameters:
LFSR_W, 7, LFSR state width; data byte width is LFSR_W+1
MSG_LEN, 64, number of ciphertext words produced
ADDR_W, 8, memory address width
SRC_BASE, 0, first address of biased plaintext (already minus 0x20)
CFG_BASE, 61, address of pre_length; taps at CFG_BASE+1, seed at CFG_BASE+2
DST_BASE, 64, first ciphertext address
PARITY, 0, 0 = MSB forced 0; 1 = MSB is even parity of the low LFSR_W bits

Ports:
clk  in  1  clock
init  in  1  synchronous active-low reset
req  in  1  start request; level high holds the engine, a high-to-low transition launches a run
ack  out  1  run complete; held high until req returns high
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  read address
rd_data  in  LFSR_W+1  read data, valid the cycle after rd_en
wr_en  out  1  memory write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  LFSR_W+1  ciphertext word

Behaviour:
- Reset: init sampled low on a rising edge forces IDLE and clears ack, rd_en, wr_en, rd_addr, wr_addr, wr_data and all internal registers. Reset mid-run aborts at once; memory already written is left as is.
- States: IDLE, CFG, RUN, DONE.
- IDLE: records req. A cycle T0 with req=0 after a previous sample of req=1 enters CFG.
- CFG: reads CFG_BASE at T0+1, CFG_BASE+1 at T0+2, CFG_BASE+2 at T0+3. All three are captured by the end of T0+4.
- Config sanitising:
  - taps are masked to LFSR_W bits;
  - seed is masked to LFSR_W bits, and a masked seed of 0 is replaced by 1;
  - a pre value above MSG_LEN clamps to MSG_LEN.
- RUN, index i = 0..MSG_LEN-1:
  - padded[i] = 0 when i<pre, or when SRC_BASE+(i-pre) >= CFG_BASE;
  - otherwise padded[i] = mem[SRC_BASE+i-pre], read at cycle T0+4+i;
  - rd_en stays low for preamble and out-of-range indices.
- Ciphertext:
  - low = padded[i][LFSR_W-1:0] ^ lfsr[i];
  - wr_data = {msb, low}, with msb = (PARITY ? ^low : 0);
  - written to DST_BASE+i at cycle T0+5+i, so writes are back to back.
- LFSR sequence:
  - lfsr[0] = sanitised seed;
  - lfsr[i+1] = {lfsr[i][LFSR_W-2:0], ^(lfsr[i] & taps)}.
- DONE: ack=1 from cycle T0+5+MSG_LEN. The engine stays in DONE until req is sampled high, then goes to IDLE with ack=0 the next cycle.
- A req change during CFG or RUN is ignored.
- Reads and writes never overlap the config words. Ciphertext does not alias plaintext for the default map.

Test Plan:
- Zero message, pre=10, taps=0x60, seed=0x01, PARITY=0 -> DST words 0..10 = 01,02,04,08,10,20,41,03,06,0C,18; first write at T0+5; ack at T0+69.
- Same as above with mem[0]=0x2D ('M'-0x20) -> DST[10]=0x35; DST[0..9] unchanged from the zero-message run.
- seed=0x00 -> output identical to seed=0x01. seed=0xFF -> DST[0]=0x7F with MSB 0.
- PARITY=1, zero message, seed=0x01, taps=0x60 -> DST[0]=0x81, DST[6]=0x41, DST[7]=0x03.
- pre=80 (above MSG_LEN) -> no rd_en pulses in RUN; all 64 words equal pure LFSR output.
- init driven low at T0+20 -> the next cycle shows ack=0, wr_en=0, state IDLE. A later req 1->0 starts a clean run with correct output.
